// File: rtl/uart_pkg.sv
// Shared UART types and oversampling constants for the receiver and future transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider: asserts tick for one cycle every DIV clocks.
module baud_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV == 0) begin : g_bad_div
    $error("baud_tick_gen: DIV must be nonzero");
  end

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register, overrun and framing flags.
module uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned OVERSAMPLE  = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       uld_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  import uart_pkg::*;

  localparam int unsigned DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);

  if (OVERSAMPLE != 16) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be 16");
  end

  logic       tick;
  logic       rx_meta;
  logic       rx_sync;
  rx_state_t  state;
  logic [3:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      rx_data      <= 8'h00;
      rx_empty     <= 1'b1;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta      <= rx;
      rx_sync      <= rx_meta;
      rx_frame_err <= 1'b0;

      if (uld_rx_data && !rx_empty) begin
        rx_empty   <= 1'b1;
        rx_overrun <= 1'b0;
      end

      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == 4'(MID_SAMPLE)) begin
              cnt <= '0;
              // A start bit that is gone by mid-bit was a glitch.
              if (!rx_sync) begin
                state <= DATA;
                idx   <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          DATA: begin
            if (cnt == 4'(OVERSAMPLE - 1)) begin
              cnt        <= '0;
              shift[idx] <= rx_sync;
              if (idx == 3'd7) begin
                state <= STOP;
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          STOP: begin
            if (cnt == 4'(OVERSAMPLE - 1)) begin
              cnt   <= '0;
              state <= IDLE;
              if (!rx_sync) begin
                rx_frame_err <= 1'b1;
              end else if (rx_empty || uld_rx_data) begin
                // Same-cycle unload frees the register for the new byte.
                rx_data    <= shift;
                rx_empty   <= 1'b0;
                rx_overrun <= 1'b0;
              end else begin
                rx_overrun <= 1'b1;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit (DIV=1).
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       uld_rx_data;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_overrun;
  logic       rx_frame_err;

  uart_rx #(.CLK_FREQ_HZ(16_000_000), .BAUD(1_000_000)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .uld_rx_data  (uld_rx_data),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  load_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    ev_t e;
    e.ferr = 1'b0;
    e.data = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr();
    ev_t e;
    e.ferr = 1'b1;
    e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic got_event(input bit ferr, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk(ferr ? "unexpected_frame_err" : "unexpected_byte", {23'd0, ferr, d}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(ferr), 32'(e.ferr));
      if (!e.ferr) chk("event_data", 32'(d), 32'(e.data));
      load_cyc = cyc;
    end
  endtask

  // Monitor: turns DUT output changes into events and checks them against the queue.
  initial begin
    logic       prev_empty;
    logic [7:0] prev_data;
    logic       prev_ferr;
    prev_empty = 1'b1;
    prev_data  = 8'h00;
    prev_ferr  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prev_empty = 1'b1;
        prev_data  = 8'h00;
        prev_ferr  = 1'b0;
      end else begin
        if (prev_ferr) chk("frame_err_width", 32'(rx_frame_err), 32'd0);
        if (rx_frame_err) got_event(1'b1, 8'h00);
        if (!rx_empty && (prev_empty || rx_data != prev_data)) got_event(1'b0, rx_data);
        prev_empty = rx_empty;
        prev_data  = rx_data;
        prev_ferr  = rx_frame_err;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      step(16);
    end
    rx = 1'b1;
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    step(1);
    uld_rx_data = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'h00);
    chk({tag, "_rx_empty"}, 32'(rx_empty), 32'd1);
    chk({tag, "_rx_overrun"}, 32'(rx_overrun), 32'd0);
    chk({tag, "_rx_frame_err"}, 32'(rx_frame_err), 32'd0);
    step(0);
  endtask

  initial begin
    int t0;
    int lat;
    reset       = 1'b1;
    rx          = 1'b1;
    uld_rx_data = 1'b0;
    step(4);
    reset = 1'b0;
    check_reset_values("reset");
    step(5);

    // A5, latency from falling edge to rx_empty low, then unload.
    expect_byte(8'hA5);
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    lat = load_cyc - t0;
    chk("a5_latency_in_153_155", 32'(lat >= 153 && lat <= 155), 32'd1);
    unload();
    @(negedge clk);
    chk("a5_empty_after_unload", 32'(rx_empty), 32'd1);
    step(5);

    // Back-to-back 3C, C3 without unload: second byte dropped.
    expect_byte(8'h3C);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    step(2);
    @(negedge clk);
    chk("overrun_data_kept", 32'(rx_data), 32'h3C);
    chk("overrun_flag_set", 32'(rx_overrun), 32'd1);
    step(0);
    unload();
    @(negedge clk);
    chk("overrun_cleared", 32'(rx_overrun), 32'd0);
    chk("overrun_empty_after_unload", 32'(rx_empty), 32'd1);
    step(5);

    // 55 with low stop bit, then a good 0F.
    expect_ferr();
    send_byte(8'h55, 1'b0);
    step(20);
    @(negedge clk);
    chk("ferr_empty_stays", 32'(rx_empty), 32'd1);
    step(0);
    expect_byte(8'h0F);
    send_byte(8'h0F, 1'b1);
    unload();
    step(5);

    // 4-cycle glitch on idle line.
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(8);
    @(negedge clk);
    chk("glitch_state_idle", 32'(dut.state), 32'(IDLE));
    chk("glitch_empty", 32'(rx_empty), 32'd1);
    chk("glitch_overrun", 32'(rx_overrun), 32'd0);
    step(10);

    // Hold 11, then 22 with unload on the frame-complete cycle.
    expect_byte(8'h11);
    send_byte(8'h11, 1'b1);
    step(5);
    expect_byte(8'h22);
    fork
      send_byte(8'h22, 1'b1);
      begin
        step(154);
        uld_rx_data = 1'b1;
        step(1);
        uld_rx_data = 1'b0;
      end
    join
    @(negedge clk);
    chk("same_cycle_data", 32'(rx_data), 32'h22);
    chk("same_cycle_empty", 32'(rx_empty), 32'd0);
    chk("same_cycle_overrun", 32'(rx_overrun), 32'd0);
    step(0);
    unload();
    step(5);

    // Reset during data bit 4 of FF, then a good 81.
    fork
      send_byte(8'hFF, 1'b1);
      begin
        step(88);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
      end
    join
    check_reset_values("midframe");
    step(10);
    expect_byte(8'h81);
    send_byte(8'h81, 1'b1);

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) step(1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver with a one-byte holding register. Sits directly upstream of `controller_fsm`: it deserialises 8N1 frames from the host line and presents each byte on `rx_data` with `rx_empty` low. The controller consumes the byte by pulsing `uld_rx_data`. Line errors are flagged, never forwarded as data.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000, system clock frequency
- `BAUD`, 115_200, line rate
- `OVERSAMPLE`, 16, sample ticks per bit (fixed at 16; the parameter exists for the package constant only)

Ports:
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `rx`  in  1  asynchronous serial line, idle high
- `uld_rx_data`  in  1  one-cycle unload strobe from the controller
- `rx_data`  out  8  held received byte
- `rx_empty`  out  1  high = no unread byte in the holding register
- `rx_overrun`  out  1  sticky: a completed frame was dropped because the register was full
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) before any use.
- Tick generator: `DIV = CLK_FREQ_HZ / (BAUD*16)` (integer; elaboration error if 0). A free-running counter runs 0..DIV-1, and `tick` is asserted when the count equals DIV-1. All FSM sampling happens only on tick cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with synced rx=0, go to START and clear the sample count.
  - START: at the 8th tick (count=7, mid-bit), if rx=0 go to DATA with bit index 0 and count cleared. If rx=1, this was a glitch: return to IDLE with no flags.
  - DATA: every 16th tick (mid-bit) shift rx into bit `[index]`, LSB first. After index 7, go to STOP.
  - STOP: at mid-bit, if rx=1 the frame is good, otherwise it is a frame error. Return to IDLE in either case, so a next start bit is accepted immediately after mid-stop.
- Holding register, evaluated on the frame-complete cycle:
  - Good frame and `rx_empty`=1: load `rx_data`, and `rx_empty` goes to 0.
  - Good frame and `rx_empty`=0 and no `uld_rx_data` in that cycle: drop the new byte, keep the old `rx_data`, set `rx_overrun`.
  - Good frame together with `uld_rx_data` in the same cycle: load the new byte, `rx_empty` stays 0, no overrun.
  - Frame error: `rx_frame_err` pulses for 1 cycle. The register and `rx_empty` are untouched.
- `uld_rx_data` with `rx_empty`=0 sets `rx_empty`=1 in the next cycle and clears `rx_overrun`. `uld_rx_data` with `rx_empty`=1 is ignored.
- `rx_data` holds its value after unload; it is only valid while `rx_empty`=0.

## Timing
- Reset values: `rx_data`=8'h00, `rx_empty`=1, `rx_overrun`=0, `rx_frame_err`=0. The FSM returns to IDLE and the tick counter and bit index are cleared.
- Reset asserted mid-frame aborts the frame. No flag is raised and no partial byte is loaded.
- Latency with DIV=1, measured from the rx falling edge to `rx_empty` low: 2 sync + 1 detect + 7 + 16×9 ≈ 154 cycles, ±1.
- Flags and `rx_empty` are registered and change on the clock edge after the mid-stop tick.
- Baud error tolerance comes from mid-bit sampling: ±1/16 bit phase due to the free-running tick.

## Structure
- `uart_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`
  - `localparam OVERSAMPLE = 16`
  - `localparam MID_SAMPLE = 7`
- Sub-module `baud_tick_gen` (parameter DIV; ports `clk`, `reset`, `tick`). It is reused by the future `uart_tx`.
- The synchroniser, FSM, shift register and holding register stay in `uart_rx`.

## Test plan
Bench parameters: `CLK_FREQ_HZ`=16_000_000, `BAUD`=1_000_000 (DIV=1, 16 cycles per bit).
- Send byte 8'hA5 with valid framing -> `rx_empty` falls at 154±1 cycles with `rx_data`=8'hA5. Pulse `uld_rx_data` -> `rx_empty`=1 on the next cycle.
- Send 8'h3C then 8'hC3 back-to-back with no unload -> `rx_data` stays 8'h3C and `rx_overrun`=1. Then unload -> `rx_overrun`=0 and `rx_empty`=1.
- Send 8'h55 with the stop bit driven low -> `rx_frame_err` high for exactly 1 cycle, `rx_empty` stays 1. A following good 8'h0F is received correctly.
- Drive a 4-cycle low glitch on idle `rx` -> no flags, `rx_empty`=1, FSM back in IDLE by cycle 12.
- With 8'h11 held, send 8'h22 and pulse `uld_rx_data` on the exact frame-complete cycle -> `rx_data`=8'h22, `rx_empty`=0, `rx_overrun`=0.
- Assert `reset` during data bit 4 of 8'hFF -> all outputs at reset values, no flags. The next frame 8'h81 is received correctly.
